seg7_scan_driver: RTL and testbench

Time-multiplexed driver for the Nexys A7 eight-digit, common-anode seven-segment display. It sits directly downstream of the game FSM and accepts eight 5-bit character codes (d1 leftmost … d8 rightmost) plus decimal-point flags. It double-buffers them and swaps buffers only at a scan-frame boundary, so the display never tears. It scans one digit at a time and drives active-low anodes and cathodes.

---
 rtl/seg7_pkg.sv | 67 ++++++
 rtl/seg7_char_decoder.sv | 44 ++++
 rtl/seg7_scan_driver.sv | 126 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - character codes and active-low segment patterns for the seg7 scan driver
package seg7_pkg;

  typedef logic [4:0] char_t;

  localparam char_t CH_0     = 5'd0;
  localparam char_t CH_1     = 5'd1;
  localparam char_t CH_2     = 5'd2;
  localparam char_t CH_3     = 5'd3;
  localparam char_t CH_4     = 5'd4;
  localparam char_t CH_5     = 5'd5;
  localparam char_t CH_6     = 5'd6;
  localparam char_t CH_7     = 5'd7;
  localparam char_t CH_8     = 5'd8;
  localparam char_t CH_9     = 5'd9;
  localparam char_t CH_A     = 5'd10;
  localparam char_t CH_B     = 5'd11;
  localparam char_t CH_C     = 5'd12;
  localparam char_t CH_D     = 5'd13;
  localparam char_t CH_E     = 5'd14;
  localparam char_t CH_F     = 5'd15;
  localparam char_t CH_G     = 5'd16;
  localparam char_t CH_J     = 5'd17;
  localparam char_t CH_L     = 5'd18;
  localparam char_t CH_P     = 5'd19;
  localparam char_t CH_S     = 5'd20;
  localparam char_t CH_T     = 5'd21;
  localparam char_t CH_U     = 5'd22;
  localparam char_t CH_Y     = 5'd23;
  localparam char_t CH_N     = 5'd24;
  localparam char_t CH_O     = 5'd25;
  localparam char_t CH_R     = 5'd26;
  localparam char_t CH_DASH  = 5'd27;
  localparam char_t CH_BLANK = 5'd31;

  // Patterns are g,f,e,d,c,b,a with a lit segment driven low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_G     = 7'b1000010;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_Y     = 7'b0010001;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_char_decoder.sv
// rtl/seg7_char_decoder.sv - combinational char code to active-low segment pattern
module seg7_char_decoder
  import seg7_pkg::*;
(
  input  char_t      char_code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (char_code)
      CH_0:    pattern = SEG_0;
      CH_1:    pattern = SEG_1;
      CH_2:    pattern = SEG_2;
      CH_3:    pattern = SEG_3;
      CH_4:    pattern = SEG_4;
      CH_5:    pattern = SEG_5;
      CH_6:    pattern = SEG_6;
      CH_7:    pattern = SEG_7;
      CH_8:    pattern = SEG_8;
      CH_9:    pattern = SEG_9;
      CH_A:    pattern = SEG_A;
      CH_B:    pattern = SEG_B;
      CH_C:    pattern = SEG_C;
      CH_D:    pattern = SEG_D;
      CH_E:    pattern = SEG_E;
      CH_F:    pattern = SEG_F;
      CH_G:    pattern = SEG_G;
      CH_J:    pattern = SEG_J;
      CH_L:    pattern = SEG_L;
      CH_P:    pattern = SEG_P;
      CH_S:    pattern = SEG_S;
      CH_T:    pattern = SEG_T;
      CH_U:    pattern = SEG_U;
      CH_Y:    pattern = SEG_Y;
      CH_N:    pattern = SEG_N;
      CH_O:    pattern = SEG_O;
      CH_R:    pattern = SEG_R;
      CH_DASH: pattern = SEG_DASH;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered eight-digit multiplexed seven-segment driver
// Defining SEG7_BLINK_EN adds a blink phase counter that blanks the anodes while blink is high.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD     = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [39:0] chars,
  input  logic [7:0]  dp,
  input  logic        blink,
  output logic        pending,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [2:0]       slot;
  logic             div_wrap;
  logic             boundary;
  logic [39:0]      stg_chars;
  logic [39:0]      shd_chars;
  logic [7:0]       stg_dp;
  logic [7:0]       shd_dp;
  char_t            slot_char;
  logic [6:0]       slot_seg;
  logic             blank;

  assign div_wrap = (div == DIV_W'(SCAN_DIV - 1));
  assign boundary = div_wrap && (slot == 3'd7);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div  <= '0;
      slot <= 3'd0;
    end else if (div_wrap) begin
      div  <= '0;
      slot <= slot + 3'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Shadow only changes on the frame boundary so a frame never mixes old and new data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stg_chars <= {8{CH_BLANK}};
      shd_chars <= {8{CH_BLANK}};
      stg_dp    <= 8'h00;
      shd_dp    <= 8'h00;
      pending   <= 1'b0;
    end else begin
      if (boundary && pending) begin
        shd_chars <= stg_chars;
        shd_dp    <= stg_dp;
      end
      if (load) begin
        stg_chars <= chars;
        stg_dp    <= dp;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  assign slot_char = shd_chars[slot*5 +: 5];

  seg7_char_decoder u_decoder (
    .char_code (slot_char),
    .pattern   (slot_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_on;
  logic               blink_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
      blink_q   <= 1'b0;
    end else begin
      blink_q <= blink;
      if (blink_q && !blink) begin
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blank = blink && !phase_on;
`else
  logic unused_blink;
  assign unused_blink = blink & (BLINK_DIV != 0);
  assign blank        = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an   <= 8'hFF;
      seg  <= 7'h7F;
      dp_n <= 1'b1;
    end else begin
      an   <= ((div < DIV_W'(GUARD)) || blank) ? 8'hFF : ~(8'h80 >> slot);
      seg  <= slot_seg;
      dp_n <= ~shd_dp[slot];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver with a frame-level reference model
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BD = 16;

  logic        clock;
  logic        reset;
  logic        load;
  logic [39:0] chars;
  logic [7:0]  dp;
  logic        blink;
  logic        pending;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int n_pass;
  int n_total;

  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_DIV(BD)) dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .chars   (chars),
    .dp      (dp),
    .blink   (blink),
    .pending (pending),
    .an      (an),
    .seg     (seg),
    .dp_n    (dp_n)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg_of(input logic [4:0] c);
    case (c)
      5'd0:  return 7'b1000000;
      5'd1:  return 7'b1111001;
      5'd2:  return 7'b0100100;
      5'd3:  return 7'b0110000;
      5'd4:  return 7'b0011001;
      5'd5:  return 7'b0010010;
      5'd6:  return 7'b0000010;
      5'd7:  return 7'b1111000;
      5'd8:  return 7'b0000000;
      5'd9:  return 7'b0010000;
      5'd10: return 7'b0001000;
      5'd11: return 7'b0000011;
      5'd12: return 7'b1000110;
      5'd13: return 7'b0100001;
      5'd14: return 7'b0000110;
      5'd15: return 7'b0001110;
      5'd16: return 7'b1000010;
      5'd17: return 7'b1100001;
      5'd18: return 7'b1000111;
      5'd19: return 7'b0001100;
      5'd20: return 7'b0010010;
      5'd21: return 7'b0000111;
      5'd22: return 7'b1000001;
      5'd23: return 7'b0010001;
      5'd24: return 7'b0101011;
      5'd25: return 7'b0100011;
      5'd26: return 7'b0101111;
      5'd27: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int slot_of(input int c);
    return (c / SD) % 8;
  endfunction

  // Reference: cyc counts cycles since reset release, so slot and divider follow by division.
  int         cyc;
  int         since;
  logic [4:0] m_stg [8];
  logic [4:0] m_shd [8];
  logic [7:0] m_stg_dp;
  logic [7:0] m_shd_dp;
  logic       m_pend;
  logic       m_blink_q;
  logic       m_blank;
  logic       m_bnd;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dpn;

`ifdef SEG7_BLINK_EN
  assign m_blank = blink && (((since / BD) % 2) == 1);
`else
  assign m_blank = 1'b0;
`endif
  assign m_bnd = ((cyc % (8 * SD)) == (8 * SD - 1));

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc       <= 0;
      since     <= 0;
      m_pend    <= 1'b0;
      m_blink_q <= 1'b0;
      m_stg_dp  <= 8'h00;
      m_shd_dp  <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        m_stg[i] <= 5'd31;
        m_shd[i] <= 5'd31;
      end
      e_an  <= 8'hFF;
      e_seg <= 7'h7F;
      e_dpn <= 1'b1;
    end else begin
      e_seg <= seg_of(m_shd[slot_of(cyc)]);
      e_dpn <= !m_shd_dp[slot_of(cyc)];
      e_an  <= (((cyc % SD) < GD) || m_blank) ? 8'hFF : ~(8'h80 >> slot_of(cyc));
      cyc   <= cyc + 1;
      since <= (m_blink_q && !blink) ? 0 : since + 1;
      m_blink_q <= blink;
      if (m_bnd && m_pend) begin
        for (int i = 0; i < 8; i++) m_shd[i] <= m_stg[i];
        m_shd_dp <= m_stg_dp;
      end
      if (load) begin
        for (int i = 0; i < 8; i++) m_stg[i] <= chars[i*5 +: 5];
        m_stg_dp <= dp;
        m_pend   <= 1'b1;
      end else if (m_bnd) begin
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    chk("an", 40'(an), 40'(e_an));
    chk("seg", 40'(seg), 40'(e_seg));
    chk("dp_n", 40'(dp_n), 40'(e_dpn));
    chk("pending", 40'(pending), 40'(m_pend));
  end

  int         flow [8];
  logic [6:0] fseg [8];
  logic       fdpn [8];
  int         saw_p2;
  int         pend_cnt;
  int         bad_an;

  task automatic capture_frame();
    logic found;
    for (int k = 0; k < 8; k++) begin
      flow[k] = 0;
      fseg[k] = 7'h00;
      fdpn[k] = 1'b0;
    end
    saw_p2 = 0;
    pend_cnt = 0;
    bad_an = 0;
    for (int n = 0; n < 8 * SD; n++) begin
      @(negedge clock);
      if (seg == 7'b0100100) saw_p2++;
      if (pending) pend_cnt++;
      if (an != 8'hFF) begin
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
          if (an == ~(8'h80 >> k)) begin
            flow[k]++;
            fseg[k] = seg;
            fdpn[k] = dp_n;
            found = 1'b1;
          end
        end
        if (!found) bad_an++;
      end
    end
  endtask

  task automatic wait_pend_clear();
    int n;
    n = 0;
    while (pending !== 1'b0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("pend_clear_timeout", 40'(n < 300), 40'd1);
  endtask

  task automatic pulse_load(input logic [39:0] c, input logic [7:0] d);
    load  = 1'b1;
    chars = c;
    dp    = d;
    @(negedge clock);
    load = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    n_pass  = 0;
    n_total = 0;
    load  = 1'b0;
    chars = '0;
    dp    = '0;
    blink = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      load  = 1'($urandom);
      chars = 40'({$urandom, $urandom});
      dp    = 8'($urandom);
      @(negedge clock);
    end
    chk("rst_an", 40'(an), 40'hFF);
    chk("rst_seg", 40'(seg), 40'h7F);
    chk("rst_dp_n", 40'(dp_n), 40'd1);
    chk("rst_pending", 40'(pending), 40'd0);
    load = 1'b0;
    reset = 1'b1;

    // First frame after release is blank; load of all ones at cycle 3.
    bad = 0;
    for (int k = 0; k < 65; k++) begin
      if (seg !== 7'h7F) bad++;
      if (k == 3) begin
        load  = 1'b1;
        chars = {8{CH_1}};
        dp    = 8'h00;
      end
      if (k == 4) begin
        load = 1'b0;
        chk("pend_after_load", 40'(pending), 40'd1);
      end
      if (k < 64) @(negedge clock);
    end
    chk("first_frame_blank", 40'(bad), 40'd0);
    wait_pend_clear();
    capture_frame();
    for (int k = 0; k < 8; k++) begin
      chk("anode_low_cycles", 40'(flow[k]), 40'd6);
      chk("ones_seg", 40'(fseg[k]), 40'b1111001);
    end
    chk("anode_onehot", 40'(bad_an), 40'd0);
    chk("ones_pending", 40'(pending), 40'd0);

    pulse_load({CH_P, CH_U, CH_T, CH_E, CH_S, CH_BLANK, CH_1, CH_J}, 8'h02);
    wait_pend_clear();
    capture_frame();
    chk("j1_d1_seg", 40'(fseg[0]), 40'b1100001);
    chk("j1_d2_seg", 40'(fseg[1]), 40'b1111001);
    chk("j1_d2_dp", 40'(fdpn[1]), 40'd0);
    chk("j1_d3_seg", 40'(fseg[2]), 40'h7F);
    chk("j1_d3_dp", 40'(fdpn[2]), 40'd1);
    chk("j1_d8_seg", 40'(fseg[7]), 40'b0001100);

    pulse_load({8{CH_2}}, 8'h00);
    pulse_load({8{CH_8}}, 8'h00);
    wait_pend_clear();
    capture_frame();
    chk("last_load_no_2", 40'(saw_p2), 40'd0);
    for (int k = 0; k < 8; k++) chk("last_load_8", 40'(fseg[k]), 40'b0000000);

    // Load exactly on the frame boundary.
    n = 0;
    while ((cyc % (8 * SD)) != 50 && n < 200) begin
      @(negedge clock);
      n++;
    end
    pulse_load({8{CH_3}}, 8'h00);
    while ((cyc % (8 * SD)) != (8 * SD - 1) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("bnd_align_timeout", 40'(n < 200), 40'd1);
    pulse_load({8{CH_5}}, 8'h00);
    chk("bnd_pending", 40'(pending), 40'd1);
    capture_frame();
    chk("bnd_old_frame", 40'(fseg[0]), 40'b0110000);
    chk("bnd_pend_between", 40'(pend_cnt), 40'd63);
    capture_frame();
    chk("bnd_new_frame", 40'(fseg[0]), 40'b0010010);
    chk("bnd_pend_after", 40'(pend_cnt), 40'd0);

    for (int i = 0; i < 2500; i++) begin
      load  = ($urandom_range(0, 15) == 0);
      chars = 40'({$urandom, $urandom});
      dp    = 8'($urandom);
      if ($urandom_range(0, 39) == 0) blink = ~blink;
      @(negedge clock);
    end
    load = 1'b0;

    // Asynchronous reset mid-scan.
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_an", 40'(an), 40'hFF);
    chk("mid_rst_seg", 40'(seg), 40'h7F);
    chk("mid_rst_dp_n", 40'(dp_n), 40'd1);
    chk("mid_rst_pending", 40'(pending), 40'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    blink = 1'b0;
    repeat (80) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
